// File: rtl/lc4_decode_stage.sv
// rtl/lc4_decode_stage.sv - LC4 decode/operand-fetch stage with 8x16 register file and write bypass
module lc4_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_insn,
  input  logic [15:0] i_pc,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [15:0] o_insn,
  output logic [15:0] o_pc,
  output logic [15:0] o_r1data,
  output logic [15:0] o_r2data,
  output logic [2:0]  o_wsel,
  output logic        o_rf_we,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_flush,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_sel,
  input  logic [15:0] i_wb_data
);

  function automatic logic [2:0] f_r1sel(input logic [15:0] insn);
    if (insn[15:12] == 4'b0010 || insn[15:12] == 4'b1101) return insn[11:9];
    return insn[8:6];
  endfunction

  function automatic logic [2:0] f_r2sel(input logic [15:0] insn);
    if (insn[15:12] == 4'b0111) return insn[11:9];
    return insn[2:0];
  endfunction

  function automatic logic [3:0] f_wdest(input logic [15:0] insn);
    case (insn[15:12])
      4'b0001, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1101: return {1'b1, insn[11:9]};
      4'b0100, 4'b1111:                                     return {1'b1, 3'd7};
      default:                                              return 4'b0000;
    endcase
  endfunction

  logic [15:0] r_rf [0:7];
  logic [15:0] r_insn;
  logic [15:0] r_pc;
  logic [15:0] r_r1data;
  logic [15:0] r_r2data;
  logic [2:0]  r_wsel;
  logic        r_rf_we;
  logic        r_valid;

  logic [2:0]  w_r1sel;
  logic [2:0]  w_r2sel;
  logic [3:0]  w_wdest;
  logic [15:0] w_r1data;
  logic [15:0] w_r2data;
  logic [2:0]  w_h_r1sel;
  logic [2:0]  w_h_r2sel;
  logic        w_capture;
  logic        w_stall;

  assign w_r1sel   = f_r1sel(i_insn);
  assign w_r2sel   = f_r2sel(i_insn);
  assign w_wdest   = f_wdest(i_insn);
  assign w_h_r1sel = f_r1sel(r_insn);
  assign w_h_r2sel = f_r2sel(r_insn);

  // Writeback data in the same cycle wins over the stored copy.
  assign w_r1data = (i_wb_we && i_wb_sel == w_r1sel) ? i_wb_data : r_rf[w_r1sel];
  assign w_r2data = (i_wb_we && i_wb_sel == w_r2sel) ? i_wb_data : r_rf[w_r2sel];

  assign o_ready   = !r_valid | i_ready;
  assign w_capture = i_valid & o_ready & !i_flush;
  assign w_stall   = r_valid & !i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) r_rf[k] <= 16'h0000;
    end else if (i_wb_we) begin
      r_rf[i_wb_sel] <= i_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_insn   <= 16'h0000;
      r_pc     <= 16'h0000;
      r_r1data <= 16'h0000;
      r_r2data <= 16'h0000;
      r_wsel   <= 3'd0;
      r_rf_we  <= 1'b0;
    end else begin
      if (i_flush)        r_valid <= 1'b0;
      else if (w_capture) r_valid <= 1'b1;
      else if (i_ready)   r_valid <= 1'b0;

      if (w_capture) begin
        r_insn   <= i_insn;
        r_pc     <= i_pc;
        r_r1data <= w_r1data;
        r_r2data <= w_r2data;
        r_wsel   <= w_wdest[2:0];
        r_rf_we  <= w_wdest[3];
      end else if (w_stall) begin
        // A stalled entry must not leave with operands older than the register file.
        if (i_wb_we && i_wb_sel == w_h_r1sel) r_r1data <= i_wb_data;
        if (i_wb_we && i_wb_sel == w_h_r2sel) r_r2data <= i_wb_data;
      end
    end
  end

  assign o_insn   = r_insn;
  assign o_pc     = r_pc;
  assign o_r1data = r_r1data;
  assign o_r2data = r_r2data;
  assign o_wsel   = r_wsel;
  assign o_rf_we  = r_rf_we;
  assign o_valid  = r_valid;

endmodule

// File: tb/tb_lc4_decode_stage.sv
// tb/tb_lc4_decode_stage.sv - self-checking bench for lc4_decode_stage
module tb_lc4_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_insn, i_pc;
  logic        i_valid, i_ready, i_flush;
  logic        i_wb_we;
  logic [2:0]  i_wb_sel;
  logic [15:0] i_wb_data;
  logic        o_ready, o_rf_we, o_valid;
  logic [15:0] o_insn, o_pc, o_r1data, o_r2data;
  logic [2:0]  o_wsel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lc4_decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .i_insn(i_insn), .i_pc(i_pc), .i_valid(i_valid), .o_ready(o_ready),
    .o_insn(o_insn), .o_pc(o_pc), .o_r1data(o_r1data), .o_r2data(o_r2data),
    .o_wsel(o_wsel), .o_rf_we(o_rf_we), .o_valid(o_valid),
    .i_ready(i_ready), .i_flush(i_flush),
    .i_wb_we(i_wb_we), .i_wb_sel(i_wb_sel), .i_wb_data(i_wb_data)
  );

  typedef struct {
    logic        wb_we;
    logic [2:0]  wb_sel;
    logic [15:0] wb_data;
    logic [15:0] insn;
    logic [15:0] pc;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [2:0]  wsel;
    logic        rf_we;
  } vec_t;

  typedef struct {
    logic [15:0] insn;
    logic [15:0] pc;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [2:0]  wsel;
    logic        rf_we;
  } exp_t;

  vec_t vecs[10];
  exp_t exp_q[$];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_insn = 16'h0000; i_pc = 16'h0000;
    i_flush = 1'b0; i_wb_we = 1'b0; i_wb_sel = 3'd0; i_wb_data = 16'h0000;
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    check16({name, " valid"}, {15'd0, o_valid}, 16'd1);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got output %h expected none", name, o_insn);
    end else begin
      e = exp_q.pop_front();
      check16({name, " insn"}, o_insn, e.insn);
      check16({name, " pc"}, o_pc, e.pc);
      check16({name, " r1data"}, o_r1data, e.r1);
      check16({name, " r2data"}, o_r2data, e.r2);
      check16({name, " wsel/we"}, {12'd0, o_rf_we, o_wsel}, {12'd0, e.rf_we, e.wsel});
    end
  endtask

  task automatic issue(input logic [15:0] insn, input logic [15:0] pc,
                       input logic [15:0] r1, input logic [15:0] r2,
                       input logic [2:0] wsel, input logic rf_we);
    exp_t e;
    i_valid = 1'b1; i_insn = insn; i_pc = pc;
    e.insn = insn; e.pc = pc; e.r1 = r1; e.r2 = r2; e.wsel = wsel; e.rf_we = rf_we;
    exp_q.push_back(e);
  endtask

  initial begin
    //           we  sel   data      insn      pc        r1        r2        wsel  we
    vecs[0] = '{1'b1, 3'd1, 16'h1234, 16'h1642, 16'h0100, 16'h1234, 16'h0000, 3'd3, 1'b1};
    vecs[1] = '{1'b1, 3'd2, 16'h0011, 16'h1642, 16'h0101, 16'h1234, 16'h0011, 3'd3, 1'b1};
    vecs[2] = '{1'b1, 3'd1, 16'hBEEF, 16'h1642, 16'h0102, 16'hBEEF, 16'h0011, 3'd3, 1'b1};
    vecs[3] = '{1'b1, 3'd5, 16'h00AB, 16'hDB12, 16'h0103, 16'h00AB, 16'h0011, 3'd5, 1'b1};
    vecs[4] = '{1'b1, 3'd6, 16'h7777, 16'h7C40, 16'h0104, 16'hBEEF, 16'h7777, 3'd0, 1'b0};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 16'h2A80, 16'h0105, 16'h00AB, 16'h0000, 3'd0, 1'b0};
    vecs[6] = '{1'b1, 3'd0, 16'h0A0A, 16'h4800, 16'h0106, 16'h0A0A, 16'h0A0A, 3'd7, 1'b1};
    vecs[7] = '{1'b1, 3'd7, 16'h1357, 16'hF0FF, 16'h0107, 16'h0000, 16'h1357, 3'd7, 1'b1};
    vecs[8] = '{1'b0, 3'd0, 16'h0000, 16'h9E05, 16'h0108, 16'h0A0A, 16'h00AB, 3'd7, 1'b1};
    vecs[9] = '{1'b0, 3'd0, 16'h0000, 16'h3000, 16'h0109, 16'h0A0A, 16'h0A0A, 3'd0, 1'b0};

    rst_n = 1'b0; i_ready = 1'b1;
    idle_inputs();
    tick(); tick();
    check16("reset valid", {15'd0, o_valid}, 16'd0);
    check16("reset insn", o_insn, 16'h0000);
    check16("reset r1/r2", o_r1data | o_r2data, 16'h0000);
    rst_n = 1'b1;
    #1;
    check16("reset ready", {15'd0, o_ready}, 16'd1);

    // Back-to-back capture with same-cycle writebacks.
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      i_wb_we = vecs[i].wb_we; i_wb_sel = vecs[i].wb_sel; i_wb_data = vecs[i].wb_data;
      issue(vecs[i].insn, vecs[i].pc, vecs[i].r1, vecs[i].r2, vecs[i].wsel, vecs[i].rf_we);
      tick();
      check_pop($sformatf("vec%0d", i));
    end

    // Stall with refresh of both operands.
    idle_inputs();
    issue(16'h1642, 16'h0200, 16'hBEEF, 16'h0011, 3'd3, 1'b1);
    tick();
    check_pop("stall capture");
    idle_inputs();
    i_ready = 1'b0;
    i_valid = 1'b1; i_insn = 16'h1000; i_pc = 16'h0201;
    i_wb_we = 1'b1; i_wb_sel = 3'd2; i_wb_data = 16'h0042;
    #1;
    check16("stall ready", {15'd0, o_ready}, 16'd0);
    tick();
    check16("refresh r2", o_r2data, 16'h0042);
    check16("refresh r1 kept", o_r1data, 16'hBEEF);
    check16("stall insn held", o_insn, 16'h1642);
    check16("stall ready2", {15'd0, o_ready}, 16'd0);
    i_wb_sel = 3'd1; i_wb_data = 16'h1111;
    tick();
    check16("refresh r1", o_r1data, 16'h1111);
    check16("stall valid", {15'd0, o_valid}, 16'd1);
    i_wb_we = 1'b0;
    i_ready = 1'b1;
    exp_q.push_back('{16'h1000, 16'h0201, 16'h0A0A, 16'h0A0A, 3'd0, 1'b1});
    #1;
    check16("release ready", {15'd0, o_ready}, 16'd1);
    tick();
    check_pop("post-stall capture");

    // Flush beats capture, keeps data, lets the write land.
    idle_inputs();
    i_valid = 1'b1; i_insn = 16'h5000; i_pc = 16'h0300; i_flush = 1'b1;
    i_wb_we = 1'b1; i_wb_sel = 3'd4; i_wb_data = 16'h4444;
    tick();
    check16("flush valid", {15'd0, o_valid}, 16'd0);
    check16("flush insn kept", o_insn, 16'h1000);
    idle_inputs();
    issue(16'h1104, 16'h0301, 16'h4444, 16'h4444, 3'd0, 1'b1);
    tick();
    check_pop("flush write landed");

    // Asynchronous reset while stalled.
    idle_inputs();
    i_ready = 1'b0;
    tick();
    check16("pre-reset valid", {15'd0, o_valid}, 16'd1);
    #3 rst_n = 1'b0;
    #1;
    check16("async valid", {15'd0, o_valid}, 16'd0);
    check16("async insn", o_insn, 16'h0000);
    check16("async pc", o_pc, 16'h0000);
    check16("async data", o_r1data | o_r2data, 16'h0000);
    check16("async wsel/we", {12'd0, o_rf_we, o_wsel}, 16'd0);
    tick();
    rst_n = 1'b1;
    i_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      idle_inputs();
      issue(16'h1000 | 16'((2 * p) << 6) | 16'(2 * p + 1), 16'h0400 + 16'(p),
            16'h0000, 16'h0000, 3'd0, 1'b1);
      tick();
      check_pop($sformatf("rf zero pair%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc4_decode_stage.md
# lc4_decode_stage

Decode/operand-fetch stage directly upstream of `lc4_alu`. It accepts a fetched instruction and PC, decodes the register selects, and reads an internal 8×16 register file with write-to-read bypass. It presents `o_insn`, `o_pc`, `o_r1data` and `o_r2data` from a one-entry pipeline register under a valid/ready handshake. The writeback stage drives the register-file write port.

## Interface
- No parameters. Data width is fixed at 16; register count is fixed at 8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_insn` in 16: fetched instruction.
- `i_pc` in 16: PC of `i_insn`.
- `i_valid` in 1: upstream offers `i_insn`/`i_pc`.
- `o_ready` out 1: stage can accept this cycle.
- `o_insn` out 16: registered instruction to the ALU.
- `o_pc` out 16: registered PC to the ALU.
- `o_r1data` out 16: registered first operand.
- `o_r2data` out 16: registered second operand.
- `o_wsel` out 3: destination register of the held instruction.
- `o_rf_we` out 1: held instruction writes a register.
- `o_valid` out 1: the output register holds a live instruction.
- `i_ready` in 1: the ALU/execute stage consumes this cycle.
- `i_flush` in 1: squash the held instruction and any capture this cycle.
- `i_wb_we` in 1: register-file write enable.
- `i_wb_sel` in 3: register-file write index.
- `i_wb_data` in 16: register-file write data.

## Operation
- Decode is combinational on `i_insn`; `op = i_insn[15:12]`.
- r1sel:
  - `i_insn[11:9]` for op 0010 (CMP*) and op 1101 (HICONST).
  - `i_insn[8:6]` otherwise.
- r2sel:
  - `i_insn[11:9]` for op 0111 (STR).
  - `i_insn[2:0]` otherwise.
- wsel and rf_we:
  - op 0001, 0101, 0110, 1001, 1010, 1101: wsel = `i_insn[11:9]`, rf_we = 1.
  - op 0100 (JSR/JSRR) and op 1111 (TRAP): wsel = 7, rf_we = 1.
  - All other ops: wsel = 0, rf_we = 0.
- Register-file read is combinational.
- Bypass: if `i_wb_we` and `i_wb_sel` equals the read select, the read returns `i_wb_data` instead of the stored value. Both ports bypass independently.
- Register-file write: on a clock edge with `i_wb_we`, store `i_wb_data` at `i_wb_sel`. All 8 registers are writable, including R0.
- Handshake: `o_ready = !o_valid | i_ready`.
  - Capture: `i_valid & o_ready & !i_flush`. Load `o_insn`, `o_pc`, the bypassed read data, `o_wsel` and `o_rf_we`, and set `o_valid`.
  - Consume without capture: clear `o_valid`.
- Stale-operand refresh: while the held entry stalls (`o_valid & !i_ready`) and `i_wb_we` targets that entry's r1sel (or r2sel), the matching output register loads `i_wb_data`. r1sel/r2sel are recomputed from `o_insn`. Both ports may refresh in the same cycle.
- Flush:
  - Clears `o_valid` on the next edge and blocks capture; `i_flush` has priority over capture.
  - Register-file writes still occur.
  - The data outputs keep their values; only `o_valid` is cleared.

## Timing
- Latency is 1 cycle from accepted input to `o_valid`.
- Throughput is 1 instruction/cycle while `i_ready` = 1.
- `o_ready` is combinational from `o_valid` and `i_ready`. There is no combinational path from `i_valid` to `o_ready`.
- Write in cycle N is visible to a read:
  - in cycle N via bypass;
  - from N+1 via storage.
- Reset (async assert, any cycle including mid-stall):
  - all 8 registers = 0x0000;
  - `o_valid` = 0;
  - `o_insn` = `o_pc` = `o_r1data` = `o_r2data` = 0x0000;
  - `o_wsel` = 0, `o_rf_we` = 0;
  - `o_ready` = 1 once reset is released. Any in-flight instruction is lost.
- Simultaneous capture and refresh is impossible: refresh needs a stalled entry, and a stall means `o_ready` = 0.
- Refresh of a flushed entry is permitted; `o_valid` stays 0.

## Test plan
- Reset and writes:
  - Reset, then write R1 = 0x1234 and R2 = 0x0011.
  - Issue ADD R3,R1,R2 (0x1642), `i_ready` = 1.
  - Next cycle: `o_valid` = 1, `o_r1data` = 0x1234, `o_r2data` = 0x0011, `o_wsel` = 3, `o_rf_we` = 1.
- Bypass:
  - Drive ADD R3,R1,R2 in the same cycle as a write of R1 = 0xBEEF.
  - Required: `o_r1data` = 0xBEEF.
- HICONST/STR selects:
  - With R5 = 0x00AB, HICONST R5,#0x12 (0xDB12) gives `o_r1data` = 0x00AB.
  - With R6 = 0x7777, STR R6,R1,#0 (0x7C40) gives `o_r2data` = 0x7777 and `o_rf_we` = 0.
- Stall and refresh:
  - Hold `i_ready` = 0 with ADD R3,R1,R2 held.
  - Write R2 = 0x0042: `o_r2data` becomes 0x0042 next cycle.
  - `o_ready` stays 0 throughout; the upstream instruction is not captured until `i_ready` = 1.
- Flush:
  - `i_flush` = 1 together with `i_valid` = 1 and `o_ready` = 1.
  - Required: `o_valid` = 0 next cycle, `o_insn` unchanged, and a concurrent write to R4 still lands.
- Async reset mid-stall:
  - Assert `rst_n` = 0 between clock edges.
  - Required: outputs zero immediately and all registers read 0x0000 afterwards.
